// File: rtl/nn_mmio_pkg.sv
// Shared definitions for the memory-mapped peripheral engines: FSM state
// encoding and the default keyboard/screen address map.
package nn_mmio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SAMPLE,
    ST_WRITE,
    ST_WAIT
  } state_t;

  localparam int KBD_ADDR    = 24576;
  localparam int SCREEN_BASE = 16384;
  localparam int SCREEN_LEN  = 8192;

endpackage

// File: rtl/dst_ring_ptr.sv
// Circular destination pointer: advances by STRIDE on each committed write and
// returns to DST_BASE past the end of the window, flagging the wrap for one cycle.
module dst_ring_ptr #(
  parameter int ADDR_W   = 15,
  parameter int DST_BASE = 16384,
  parameter int DST_LEN  = 8192,
  parameter int STRIDE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap_pulse
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W:0]   LAST_X   = (ADDR_W+1)'(DST_BASE + DST_LEN - 1);
  localparam logic [ADDR_W:0]   STRIDE_X = (ADDR_W+1)'(STRIDE);

  // One extra bit so a window ending at the top of the address space still compares correctly
  logic [ADDR_W:0] next_x;
  assign next_x = {1'b0, ptr} + STRIDE_X;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= BASE;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (advance) begin
        if (next_x > LAST_X) begin
          ptr        <= BASE;
          wrap_pulse <= 1'b1;
        end else begin
          ptr <= next_x[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/kbd_echo_dma.sv
// Poll-and-copy engine: polls SRC_ADDR and writes qualifying nonzero samples into a
// circular window. Define KBD_ECHO_EDGE_DETECT_EN for one echo per keypress.
module kbd_echo_dma
  import nn_mmio_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int SRC_ADDR = KBD_ADDR,
  parameter int DST_BASE = SCREEN_BASE,
  parameter int DST_LEN  = SCREEN_LEN,
  parameter int STRIDE   = 1,
  parameter int POLL_DIV = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              wrap_pulse,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_ADDR);
  localparam logic [15:0]       DIV_LAST = (POLL_DIV > 0) ? 16'(POLL_DIV - 1) : 16'd0;
  localparam state_t            ST_AFTER = (POLL_DIV == 0) ? ST_READ : ST_WAIT;

  state_t            state, state_nx;
  logic [DATA_W-1:0] smp;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       div_cnt;
  logic              qualify;
  logic              commit;

`ifdef KBD_ECHO_EDGE_DETECT_EN
  logic [DATA_W-1:0] prev;
  assign qualify = (mem_out != '0) && (mem_out != prev);
`else
  assign qualify = (mem_out != '0);
`endif

  assign commit = (state == ST_WRITE) && mem_gnt;
  assign mem_in = smp;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // A started write always finishes; en only decides where the engine goes afterwards
  always_comb begin
    state_nx    = state;
    mem_address = addr_q;
    mem_load    = 1'b0;
    case (state)
      ST_IDLE: if (en) state_nx = ST_READ;
      ST_READ: begin
        mem_address = SRC_A;
        if (!en)          state_nx = ST_IDLE;
        else if (mem_gnt) state_nx = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (!en)          state_nx = ST_IDLE;
        else if (qualify) state_nx = ST_WRITE;
        else              state_nx = ST_AFTER;
      end
      ST_WRITE: begin
        mem_address = ptr;
        mem_load    = 1'b1;
        if (mem_gnt) state_nx = en ? ST_AFTER : ST_IDLE;
      end
      ST_WAIT: begin
        if (!en)                     state_nx = ST_IDLE;
        else if (div_cnt == DIV_LAST) state_nx = ST_READ;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      smp      <= '0;
      div_cnt  <= '0;
      wr_count <= '0;
`ifdef KBD_ECHO_EDGE_DETECT_EN
      prev     <= '0;
`endif
    end else begin
      addr_q <= mem_address;
      if (state == ST_SAMPLE) begin
        smp  <= mem_out;
`ifdef KBD_ECHO_EDGE_DETECT_EN
        prev <= mem_out;
`endif
      end
      if (commit && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      div_cnt <= ((state == ST_WAIT) && (state_nx == ST_WAIT)) ? div_cnt + 16'd1 : 16'd0;
    end
  end

  dst_ring_ptr #(
    .ADDR_W  (ADDR_W),
    .DST_BASE(DST_BASE),
    .DST_LEN (DST_LEN),
    .STRIDE  (STRIDE)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .advance   (commit),
    .ptr       (ptr),
    .wrap_pulse(wrap_pulse)
  );

endmodule

// File: tb/tb_kbd_echo_dma.sv
// Bench for kbd_echo_dma: a short-window instance checked against a write scoreboard
// every cycle, plus a divided-poll instance checked with directed cycle expectations.
module tb_kbd_echo_dma;

  localparam int SRC  = 24576;
  localparam int BASE = 16384;
  localparam int LEN  = 4;
  localparam int STR  = 1;
`ifdef KBD_ECHO_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mem_gnt = 1'b1;
  logic [14:0] mem_address;
  logic        mem_load;
  logic [15:0] mem_in;
  logic [15:0] mem_out = 16'hDEAD;
  logic        busy, wrap_pulse;
  logic [15:0] wr_count;
  logic [15:0] src = 16'h0000;

  logic        en2 = 1'b0;
  logic        mem_gnt2 = 1'b1;
  logic [14:0] mem_address2;
  logic        mem_load2;
  logic [15:0] mem_in2;
  logic [15:0] mem_out2 = 16'hDEAD;
  logic        busy2, wrap_pulse2;
  logic [15:0] wr_count2;
  logic [15:0] src2 = 16'h0000;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    bit          last;
  } wr_t;

  wr_t         expQ[$];
  logic [14:0] logAddr[$];
  logic [15:0] logData[$];
  int          checks = 0;
  int          passes = 0;
  int          modelIdx = 0;
  logic [15:0] modelPrev = 16'h0000;
  bit          checking = 1'b0;
  bit          pendCommit = 1'b0;
  bit          pendWrap = 1'b0;
  bit          pendRst = 1'b0;
  int          modelCount = 0;
  int          base = 0;

  always #5 clk = ~clk;

  kbd_echo_dma #(.DST_LEN(LEN), .STRIDE(STR), .POLL_DIV(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_gnt(mem_gnt),
    .mem_address(mem_address), .mem_load(mem_load), .mem_in(mem_in), .mem_out(mem_out),
    .busy(busy), .wrap_pulse(wrap_pulse), .wr_count(wr_count)
  );

  kbd_echo_dma #(.DST_LEN(8), .STRIDE(2), .POLL_DIV(3)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .mem_gnt(mem_gnt2),
    .mem_address(mem_address2), .mem_load(mem_load2), .mem_in(mem_in2), .mem_out(mem_out2),
    .busy(busy2), .wrap_pulse(wrap_pulse2), .wr_count(wr_count2)
  );

  // Memories: the source word answers granted reads; anything else returns garbage
  always @(posedge clk) begin
    mem_out  <= (mem_gnt && !mem_load && mem_address == 15'(SRC)) ? src : 16'hDEAD;
    mem_out2 <= (mem_gnt2 && !mem_load2 && mem_address2 == 15'(SRC)) ? src2 : 16'hDEAD;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  function automatic bit qualifies(input logic [15:0] v);
    return (v != 16'h0000) && (!EDGE || v != modelPrev);
  endfunction

  // One poll, entered at the negedge of its READ cycle
  task automatic applyStimulus(input logic [15:0] value, input int stall, input bit rstInWrite);
    bit  q;
    wr_t w;
    int  off;
    q = qualifies(value);
    modelPrev = value;
    src = value;
    if (q) begin
      off    = (modelIdx * STR) % LEN;
      w.addr = 15'(BASE + off);
      w.data = value;
      w.last = (off + STR > LEN - 1);
      expQ.push_back(w);
      modelIdx++;
    end
    @(negedge clk);
    @(negedge clk);
    if (q) begin
      if (rstInWrite) begin
        mem_gnt = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_load", mem_load, 1'b0);
        checkOutput("rst_mem_address", mem_address, 15'd0);
        checkOutput("rst_wr_count", wr_count, 16'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_mem_in", mem_in, 16'd0);
        rst = 1'b0;
        mem_gnt = 1'b1;
        modelIdx = 0;
        modelPrev = 16'h0000;
      end else begin
        if (stall > 0) begin
          mem_gnt = 1'b0;
          repeat (stall) @(negedge clk);
          mem_gnt = 1'b1;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic startEngine();
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic stopEngine();
    en = 1'b0;
    src = 16'h0000;
    @(negedge clk);
    checkOutput("busy_after_stop", busy, 1'b0);
  endtask

  // Scoreboard compare on the main instance, every cycle once out of initial reset
  initial begin
    wait (checking);
    forever begin
      @(negedge clk);
      #1;
      if (pendRst) begin
        expQ.delete();
        modelCount = 0;
        pendCommit = 1'b0;
        pendWrap = 1'b0;
      end else if (pendCommit) begin
        if (modelCount < 65535) modelCount++;
      end
      checkOutput("wrap_pulse", wrap_pulse, pendWrap);
      checkOutput("wr_count", wr_count, modelCount);
      pendCommit = 1'b0;
      pendWrap = 1'b0;
      if (mem_load) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", mem_address, mem_in);
        end else begin
          checkOutput("write_addr", mem_address, expQ[0].addr);
          checkOutput("write_data", mem_in, expQ[0].data);
          if (mem_gnt && !rst) begin
            pendCommit = 1'b1;
            pendWrap = expQ[0].last;
            logAddr.push_back(mem_address);
            logData.push_back(mem_in);
            void'(expQ.pop_front());
          end
        end
      end
      pendRst = rst;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    checkOutput("reset_mem_address", mem_address, 15'd0);
    checkOutput("reset_mem_load", mem_load, 1'b0);
    checkOutput("reset_mem_in", mem_in, 16'd0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_wrap_pulse", wrap_pulse, 1'b0);
    checkOutput("reset_wr_count", wr_count, 16'd0);
    checkOutput("reset_busy2", busy2, 1'b0);
    checkOutput("reset_wr_count2", wr_count2, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Divided polling: READ in cycles 1, 6, 11; the key seen at 11 is written in 13
    en2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checkOutput($sformatf("div_busy_c%0d", k), busy2, (k <= 15) ? 1'b1 : 1'b0);
      if (k == 12) checkOutput("div_no_early_write", mem_load2, 1'b0);
      if (k == 13) begin
        checkOutput("div_write_load", mem_load2, 1'b1);
        checkOutput("div_write_addr", mem_address2, 15'd16384);
        checkOutput("div_write_data", mem_in2, 16'h0055);
        checkOutput("div_count_before", wr_count2, 16'd0);
      end
      if (k == 14) begin
        checkOutput("div_count_after", wr_count2, 16'd1);
        checkOutput("div_load_released", mem_load2, 1'b0);
        checkOutput("div_no_wrap", wrap_pulse2, 1'b0);
      end
      if (k == 11) src2 = 16'h0055;
      if (k == 12) src2 = 16'h0000;
      if (k == 15) en2 = 1'b0;
    end

    // Five distinct keys into a 4-word window: last write wraps to the base
    startEngine();
    for (int v = 1; v <= 5; v++) applyStimulus(16'(v), 0, 1'b0);
    stopEngine();
    checkOutput("ringA_count", wr_count, 16'd5);
    checkOutput("ringA_logged", logAddr.size(), 5);
    for (int i = 0; i < 5 && i < logAddr.size(); i++) begin
      checkOutput($sformatf("ringA_addr%0d", i), logAddr[i], (i == 4) ? 15'd16384 : 15'(16384 + i));
      checkOutput($sformatf("ringA_data%0d", i), logData[i], 16'(i + 1));
    end

    // Stalled write, then a reset landing in the middle of the next write
    startEngine();
    applyStimulus(16'h0077, 5, 1'b0);
    checkOutput("stall_count", wr_count, 16'd6);
    if (logAddr.size() >= 6) checkOutput("stall_addr", logAddr[5], 15'd16385);
    else checkOutput("stall_logged", logAddr.size(), 6);
    applyStimulus(16'h0066, 0, 1'b1);
    @(negedge clk);

    // Held key, release, press again
    base = logAddr.size();
    startEngine();
    repeat (10) applyStimulus(16'h0041, 0, 1'b0);
    applyStimulus(16'h0042, 0, 1'b0);
    applyStimulus(16'h0000, 0, 1'b0);
    applyStimulus(16'h0042, 0, 1'b0);
    stopEngine();
    checkOutput("seq_count", wr_count, EDGE ? 16'd3 : 16'd12);
    if (logAddr.size() >= base + 3) begin
      checkOutput("seq_addr0", logAddr[base], 15'd16384);
      checkOutput("seq_addr1", logAddr[base+1], 15'd16385);
      checkOutput("seq_addr2", logAddr[base+2], 15'd16386);
      checkOutput("seq_data0", logData[base], 16'h0041);
      checkOutput("seq_data1", logData[base+1], EDGE ? 16'h0042 : 16'h0041);
      checkOutput("seq_data2", logData[base+2], EDGE ? 16'h0042 : 16'h0041);
    end else begin
      checkOutput("seq_logged", logAddr.size() - base, 3);
    end
    checkOutput("pending_writes", expQ.size(), 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/kbd_echo_dma.md
Name: kbd_echo_dma

Overview:
- Parametrised memory-mapped poll-and-copy engine, successor to the keyboard-to-screen echo harness.
- Polls one source word, normally the keyboard register, through the shared data-memory port.
- Writes each qualifying nonzero sample into a circular destination window, normally screen RAM, at a configurable stride.
- Adds bus-grant stalling, poll-rate division, enable control and status outputs. Sits beside the CPU on the Peripherals memory interface.

Parameters:
- ADDR_W, 15, memory address width.
- DATA_W, 16, memory data width.
- SRC_ADDR, 24576, polled source address.
- DST_BASE, 16384, first destination address.
- DST_LEN, 8192, destination window length in words. Must be ≥ STRIDE and a multiple of STRIDE.
- STRIDE, 1, destination pointer increment per write.
- POLL_DIV, 0, idle cycles inserted between polls.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  1  engine enable.
- mem_gnt  in  1  bus granted this cycle; a request completes only on a cycle with mem_gnt=1.
- mem_address  out  ADDR_W  memory address.
- mem_load  out  1  write strobe.
- mem_in  out  DATA_W  write data.
- mem_out  in  DATA_W  read data, valid one cycle after the address is presented with grant.
- busy  out  1  high in any state other than IDLE.
- wrap_pulse  out  1  one-cycle pulse when the pointer wraps.
- wr_count  out  16  completed writes, saturating at 0xFFFF.

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: mem_address=0, mem_load=0, mem_in=0, busy=0, wrap_pulse=0, wr_count=0.
  - Internal: ptr=DST_BASE, prev=0, div counter=0, state=IDLE.
  - Reset takes effect on the next edge even mid-write; no partial write survives.
- States: IDLE, READ, SAMPLE, WRITE, WAIT.
- IDLE: if en=1, go to READ.
- READ:
  - Drive mem_address=SRC_ADDR, mem_load=0.
  - Advance to SAMPLE only on a cycle with mem_gnt=1; otherwise hold.
  - en=0 → IDLE.
- SAMPLE:
  - Capture mem_out into smp.
  - If smp≠0 (and smp≠prev when the feature is enabled), go to WRITE. Otherwise go to WAIT, or to READ if POLL_DIV=0.
  - prev<=smp on every sample, including zero, so a repeated key after release echoes again.
  - en=0 → IDLE without writing.
- WRITE:
  - Drive mem_address=ptr, mem_in=smp, mem_load=1.
  - Hold all three stable while mem_gnt=0.
  - On the grant cycle, the write commits:
    - ptr advances by STRIDE; if ptr+STRIDE > DST_BASE+DST_LEN-1, ptr=DST_BASE and wrap_pulse=1 on the next cycle. Compare in ADDR_W+1 bits.
    - wr_count increments, saturating.
    - Next state: WAIT, or READ if POLL_DIV=0.
  - en=0 does not abort WRITE; the write completes, then the engine goes to IDLE.
  - mem_load returns to 0 the cycle after the commit.
- WAIT: counts POLL_DIV cycles, then READ. en=0 → IDLE.
- Timing:
  - mem_address holds its last value when not driving; mem_load=0 outside WRITE.
  - With mem_gnt tied 1 and POLL_DIV=0, the poll period is 2 cycles when nothing is written and 3 cycles with a write.

Optional Feature:
- Macro KBD_ECHO_EDGE_DETECT_EN.
- Defined: write only when smp≠0 and smp≠prev, i.e. one echo per keypress.
- Undefined: every nonzero sample is written, giving auto-repeat at poll rate (legacy behaviour); the prev register is removed.

Decomposition:
- Shared package nn_mmio_pkg holds:
  - State encoding for the five states.
  - Address-map constants: KBD_ADDR=24576, SCREEN_BASE=16384, SCREEN_LEN=8192.
- One natural sub-module: dst_ring_ptr, holding the pointer register, stride advance, wrap compare and wrap_pulse, parametrised by ADDR_W/DST_BASE/DST_LEN/STRIDE.

Test Plan:
1. Defaults, gnt=1, source holds 0x0041, no edge macro → writes 0x0041 to 16384, 16385, 16386…, one every 3 cycles; wr_count tracks.
2. KBD_ECHO_EDGE_DETECT_EN, source sequence 0x41 ×10 polls, then 0x42, then 0, then 0x42 → exactly three writes at 16384, 16385, 16386 with data 0x41, 0x42, 0x42.
3. DST_LEN=4, STRIDE=1, five nonzero samples → write addresses 16384..16387 then 16384; wrap_pulse one cycle after the 4th commit.
4. mem_gnt=0 for 5 cycles during WRITE → mem_address, mem_in and mem_load=1 stable; single commit on grant; wr_count +1 only.
5. rst=1 during WRITE → next cycle mem_load=0, mem_address=0, wr_count=0; the first post-reset write goes to 16384.
6. POLL_DIV=3, source=0 → SRC_ADDR presented with grant every 5 cycles; busy=1 throughout; en=0 in WAIT → IDLE, busy=0 next cycle.
